mem_arbiter_responder: RTL

- Responder side of the request-unit protocol: accepts instruction-fetch and data read/write requests from the request unit and answers with i_ready/d_ready and returned data.
- Serialises both request streams onto one single-port memory bus with a req/ack handshake.
- Grants data first, with anti-starvation alternation when both are pending.
- Sits between the request unit and the memory/bus wrapper.

---
 rtl/mem_arbiter_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter_responder.sv
// mem_arbiter_responder
//   Responder for the request unit: takes instruction-fetch and data
//   read/write requests, serialises them onto one single-port memory bus
//   (req/ack handshake) and answers with one-cycle i_ready / d_ready pulses
//   plus returned data. Data wins arbitration unless it was also the last
//   grantee while a fetch is waiting, so both streams make progress.
//
// Ports
//   clk, rst                         clock / synchronous active-high reset
//   imemRen, imemaddr                fetch request (held until i_ready)
//   dmmRen, dmmWen, dmmaddr,
//   dmmstore, d_fetch                data request (held until d_ready)
//   i_ready, imemload                fetch done pulse / fetched word (held)
//   d_ready, dmmload                 data done pulse / read word (held)
//   bus_err                          pulses with ready when the bus timed out
//   mem_ren, mem_wen, mem_addr,
//   mem_wdata, mem_sel               bus request, held until mem_ack
//   mem_rdata, mem_ack               bus completion
module mem_arbiter_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imemRen,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmmRen,
    input  logic              dmmWen,
    input  logic [ADDR_W-1:0] dmmaddr,
    input  logic [DATA_W-1:0] dmmstore,
    input  logic [3:0]        d_fetch,
    output logic              i_ready,
    output logic [DATA_W-1:0] imemload,
    output logic              d_ready,
    output logic [DATA_W-1:0] dmmload,
    output logic              bus_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_t;

    state_t     state, state_nxt;
    logic       last_d;     // 1: data was granted last
    logic [7:0] cnt;        // cycles spent waiting for mem_ack
    logic       grant_d, grant_i, timed_out, done;

    always_comb begin
        grant_d   = (dmmRen | dmmWen) && (!imemRen || !last_d);
        grant_i   = imemRen && !grant_d;
        // Abort on the last allowed strobe cycle; an ack there still wins.
        timed_out = !mem_ack && (cnt == 8'(TIMEOUT - 1));
        done      = mem_ack || timed_out;
        state_nxt = state;
        case (state)
            IDLE:           if (grant_d) state_nxt = D_BUSY;
                            else if (grant_i) state_nxt = I_BUSY;
            D_BUSY, I_BUSY: if (done) state_nxt = RESP;
            RESP:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d    <= 1'b0;
            cnt       <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            imemload  <= '0;
            dmmload   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr  <= dmmaddr;
                        mem_wdata <= dmmstore;
                        mem_sel   <= d_fetch;
                        // Write takes priority when both strobes are requested.
                        mem_wen   <= dmmWen;
                        mem_ren   <= !dmmWen;
                        last_d    <= 1'b1;
                        cnt       <= '0;
                    end else if (grant_i) begin
                        mem_addr  <= imemaddr;
                        mem_wdata <= '0;
                        mem_sel   <= 4'hF;
                        mem_wen   <= 1'b0;
                        mem_ren   <= 1'b1;
                        last_d    <= 1'b0;
                        cnt       <= '0;
                    end
                end
                D_BUSY, I_BUSY: begin
                    if (done) begin
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        bus_err <= !mem_ack;
                        if (state == I_BUSY) begin
                            i_ready  <= 1'b1;
                            imemload <= mem_ack ? mem_rdata : '0;
                        end else begin
                            d_ready <= 1'b1;
                            if (mem_ren) dmmload <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
